// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result signal bundle for serial_adder (optional sub under SERIAL_ADDER_SUB_EN)
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s_out;
    logic             c_out;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a_in, b_in, c_in, sub, input busy, done, s_out, c_out);
    modport slave  (input start, a_in, b_in, c_in, sub, output busy, done, s_out, c_out);
`else
    modport master (output start, a_in, b_in, c_in, input busy, done, s_out, c_out);
    modport slave  (input start, a_in, b_in, c_in, output busy, done, s_out, c_out);
`endif
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder, DIGIT bits per cycle; SERIAL_ADDER_SUB_EN adds a subtract mode
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic         clock,
    input  logic         reset,
    serial_adder_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be 2..64 and DIGIT must divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             accept;
    logic             last_digit;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, s_q;
    logic             carry_q, c_q, done_q;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    assign last_digit = (cnt_q == CW'(STEPS - 1));

    // One digit of A + B + carry; the digit sum enters the accumulator from the top
    assign dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign acc_next = (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1, so invert B and force the carry at load time
    assign b_load     = bus.sub ? ~bus.b_in : bus.b_in;
    assign carry_load = bus.sub ? 1'b1 : bus.c_in;
`else
    assign b_load     = bus.b_in;
    assign carry_load = bus.c_in;
`endif

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start is only honoured in IDLE or DONE
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin state_d = RUN; accept = 1'b1; end
            RUN:  if (last_digit) state_d = DONE;
            DONE: begin
                if (bus.start) begin state_d = RUN; accept = 1'b1; end
                else           state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, digit-serial datapath and result registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a_in;
            b_q     <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            acc_q   <= acc_next;
            carry_q <= dsum[DIGIT];
            cnt_q   <= cnt_q + 1'b1;
            if (last_digit) begin
                s_q <= acc_next;
                c_q <= dsum[DIGIT];
            end
        end
    end

    // done pulses for the cycle following DONE, giving STEPS+1 cycles of latency
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) done_q <= 1'b0;
        else        done_q <= (state_q == DONE);
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.s_out = s_q;
    assign bus.c_out = c_q;
endmodule
